// File: rtl/conv_layer_sequencer.sv
// Control sequencer for one convolution layer: loads the input feature map,
// then for each pass of PAR filters loads weights and sweeps all windows.
module conv_layer_sequencer #(
  parameter int IN_W     = 14,
  parameter int IN_H     = 14,
  parameter int IN_CH    = 6,
  parameter int K        = 5,
  parameter int OUT_CH   = 16,
  parameter int PAR      = 2,
  parameter int RD_LAT   = 2,
  parameter int PIPE_LAT = 10,
  parameter int WBASE    = 0,
  parameter int FADDR_W  = 8,
  parameter int WADDR_W  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic [FADDR_W-1:0] feat_addr,
  output logic               feat_re,
  output logic               inp_we,
  output logic [3:0]         inp_row,
  output logic [3:0]         inp_col,
  output logic [WADDR_W-1:0] weight_addr,
  output logic               weight_re,
  output logic               wt_we,
  output logic [9:0]         wt_idx,
  output logic [3:0]         win_row,
  output logic [3:0]         win_col,
  output logic               conv_valid,
  output logic [3:0]         pass_idx,
  output logic               busy,
  output logic               done
);

  localparam int NIN   = IN_W * IN_H;
  localparam int WPP   = PAR * IN_CH * K * K;
  localparam int OW    = IN_W - K + 1;
  localparam int OH    = IN_H - K + 1;
  localparam int NWIN  = OW * OH;
  localparam int NPASS = OUT_CH / PAR;

  localparam logic [15:0] INP_LAST  = 16'(NIN + RD_LAT - 1);
  localparam logic [15:0] W_LAST    = 16'(WPP + RD_LAT - 1);
  localparam logic [15:0] CONV_LAST = 16'(NWIN + PIPE_LAT - 1);

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    LOAD_INP = 5'b00010,
    LOAD_W   = 5'b00100,
    CONV     = 5'b01000,
    DONE     = 5'b10000
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt;
  logic        last_pass;

  // Read-data return pipelines: valid bit plus the address/index it belongs to.
  logic [RD_LAT-1:0]  inp_v, wt_v;
  logic [FADDR_W-1:0] inp_a [RD_LAT];
  logic [9:0]         wt_i  [RD_LAT];

  assign last_pass = (pass_idx == 4'(NPASS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (start) state_n = LOAD_INP;
      LOAD_INP: if (cnt == INP_LAST) state_n = LOAD_W;
      LOAD_W:   if (cnt == W_LAST) state_n = CONV;
      CONV:     if (cnt == CONV_LAST) state_n = last_pass ? DONE : LOAD_W;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign feat_re     = (state == LOAD_INP) && (cnt < 16'(NIN));
  assign feat_addr   = feat_re ? FADDR_W'(cnt) : '0;
  assign weight_re   = (state == LOAD_W) && (cnt < 16'(WPP));
  assign weight_addr = weight_re ? WADDR_W'(WBASE + int'(pass_idx) * WPP + int'(cnt)) : '0;
  assign conv_valid  = (state == CONV) && (cnt < 16'(NWIN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      pass_idx <= '0;
      win_row  <= '0;
      win_col  <= '0;
    end else if (abort) begin
      cnt      <= '0;
      pass_idx <= '0;
      win_row  <= '0;
      win_col  <= '0;
    end else begin
      // cnt is the cycle offset inside the current state; it restarts on every transition.
      cnt <= (state_n != state || state == IDLE) ? '0 : cnt + 16'd1;
      if (state == CONV && state_n == LOAD_W) pass_idx <= pass_idx + 4'd1;
      else if (state_n == DONE)               pass_idx <= '0;
      if (conv_valid) begin
        if (win_col == 4'(OW - 1)) begin
          win_col <= '0;
          win_row <= (win_row == 4'(OH - 1)) ? '0 : win_row + 4'd1;
        end else begin
          win_col <= win_col + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inp_v <= '0;
      wt_v  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        inp_a[i] <= '0;
        wt_i[i]  <= '0;
      end
    end else if (abort) begin
      inp_v <= '0;
      wt_v  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        inp_a[i] <= '0;
        wt_i[i]  <= '0;
      end
    end else begin
      inp_v[0] <= feat_re;
      inp_a[0] <= feat_addr;
      wt_v[0]  <= weight_re;
      wt_i[0]  <= weight_re ? 10'(cnt) : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        inp_v[i] <= inp_v[i-1];
        inp_a[i] <= inp_a[i-1];
        wt_v[i]  <= wt_v[i-1];
        wt_i[i]  <= wt_i[i-1];
      end
    end
  end

  assign inp_we  = inp_v[RD_LAT-1];
  assign inp_row = 4'(int'(inp_a[RD_LAT-1]) / IN_W);
  assign inp_col = 4'(int'(inp_a[RD_LAT-1]) % IN_W);
  assign wt_we   = wt_v[RD_LAT-1];
  assign wt_idx  = wt_i[RD_LAT-1];

endmodule
